// File: rtl/sdram_read.sv
// Single read burst on the SDRAM: ACTIVE, tRCD, READ, capture the burst, burst-stop,
// precharge all banks, tRP, then a one-cycle rd_end pulse.
module sdram_read #(
  parameter int CAS_LATENCY = 3,
  parameter int RD_TRCD_CLK = 2,
  parameter int RD_TRP_CLK  = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_sdram_data,
  output logic        rd_fifo_wr_en,
  output logic [15:0] rd_fifo_wr_data,
  output logic        rd_end,
  output logic        rd_busy,
  output logic [3:0]  read_cmd,
  output logic [1:0]  read_ba,
  output logic [12:0] read_addr
);

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_BTERM  = 4'b0110;
  localparam logic [3:0] CMD_PRE    = 4'b0010;

  localparam logic [9:0] TRCD_LAST = 10'(RD_TRCD_CLK - 1);
  localparam logic [9:0] CL_LAST   = 10'(CAS_LATENCY - 1);
  localparam logic [9:0] TRP_LAST  = 10'(RD_TRP_CLK - 1);

  typedef enum logic [3:0] {
    RD_IDLE, RD_ACTIVE, RD_TRCD, RD_READ, RD_RDATA, RD_CL, RD_PRE, RD_TRP, RD_END
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [9:0]  len_q, len_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] baddr_q, baddr_d;
  logic        end_q;
  logic        wr_en_q;
  logic [15:0] wr_data_q;
  logic        rdata_last;

  // One bit per cycle of CAS latency; the tap at the end marks cycles carrying valid dq.
  logic [CAS_LATENCY-1:0] valid_pipe_q;
  logic [CAS_LATENCY:0]   valid_pipe;

  assign rdata_last = (cnt_q == len_q - 10'd1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cmd_d   = CMD_NOP;
    ba_d    = 2'b11;
    baddr_d = 13'h1fff;
    case (state_q)
      RD_IDLE: begin
        if (rd_en && init_end) begin
          state_d = RD_ACTIVE;
          addr_d  = rd_addr;
          if (rd_burst_len == 10'd0)        len_d = 10'd1;
          else if (rd_burst_len > 10'd512)  len_d = 10'd512;
          else                              len_d = rd_burst_len;
        end
      end
      RD_ACTIVE: begin
        state_d = RD_TRCD;
        cmd_d   = CMD_ACTIVE;
        ba_d    = addr_q[23:22];
        baddr_d = addr_q[21:9];
      end
      RD_TRCD: if (cnt_q == TRCD_LAST) state_d = RD_READ;
      RD_READ: begin
        state_d = RD_RDATA;
        cmd_d   = CMD_READ;
        ba_d    = addr_q[23:22];
        baddr_d = {4'b0000, addr_q[8:0]};
      end
      RD_RDATA: begin
        if (rdata_last) begin
          state_d = RD_CL;
          cmd_d   = CMD_BTERM;
        end
      end
      RD_CL:  if (cnt_q == CL_LAST) state_d = RD_PRE;
      RD_PRE: begin
        state_d = RD_TRP;
        cmd_d   = CMD_PRE;
      end
      RD_TRP: if (cnt_q == TRP_LAST) state_d = RD_END;
      RD_END: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == RD_IDLE) ? 10'd0 : cnt_q + 10'd1;
  end

  assign valid_pipe[0]             = (state_q == RD_RDATA);
  assign valid_pipe[CAS_LATENCY:1] = valid_pipe_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= RD_IDLE;
      cnt_q        <= 10'd0;
      addr_q       <= 24'd0;
      len_q        <= 10'd1;
      cmd_q        <= CMD_NOP;
      ba_q         <= 2'b11;
      baddr_q      <= 13'h1fff;
      end_q        <= 1'b0;
      valid_pipe_q <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cmd_q        <= cmd_d;
      ba_q         <= ba_d;
      baddr_q      <= baddr_d;
      end_q        <= (state_d == RD_END);
      valid_pipe_q <= valid_pipe[CAS_LATENCY-1:0];
      wr_en_q      <= valid_pipe_q[CAS_LATENCY-1];
      if (valid_pipe_q[CAS_LATENCY-1]) wr_data_q <= rd_sdram_data;
    end
  end

  assign rd_fifo_wr_en   = wr_en_q;
  assign rd_fifo_wr_data = wr_data_q;
  assign rd_end          = end_q;
  assign rd_busy         = (state_q != RD_IDLE);
  assign read_cmd        = cmd_q;
  assign read_ba         = ba_q;
  assign read_addr       = baddr_q;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: burst-timeline model checked every cycle, plus literal timing pins.
module tb_sdram_read;

  localparam int CL = 3, TRCD = 2, TRP = 2;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101,
                         C_BT = 4'b0110, C_PRE = 4'b0010;

  logic        sys_clk = 1'b0, sys_rst = 1'b1, init_end = 1'b0, rd_en = 1'b0;
  logic [23:0] rd_addr = 24'd0;
  logic [9:0]  rd_burst_len = 10'd0;
  logic [15:0] rd_sdram_data = 16'd0;
  logic        rd_fifo_wr_en, rd_end, rd_busy;
  logic [15:0] rd_fifo_wr_data;
  logic [3:0]  read_cmd;
  logic [1:0]  read_ba;
  logic [12:0] read_addr;

  sdram_read #(.CAS_LATENCY(CL), .RD_TRCD_CLK(TRCD), .RD_TRP_CLK(TRP)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_burst_len(rd_burst_len), .rd_sdram_data(rd_sdram_data),
    .rd_fifo_wr_en(rd_fifo_wr_en), .rd_fifo_wr_data(rd_fifo_wr_data), .rd_end(rd_end),
    .rd_busy(rd_busy), .read_cmd(read_cmd), .read_ba(read_ba), .read_addr(read_addr)
  );

  always #5 sys_clk = ~sys_clk;

  int compared = 0, mismatched = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // dq carries a cycle stamp so each captured word identifies its source cycle.
  always @(posedge sys_clk) begin
    #1;
    rd_sdram_data = 16'hD000 | 16'(cyc & 'hfff);
  end

  // Model: a burst started at the end of cycle S has a fixed timeline of absolute cycles.
  bit          bv = 0;
  int          ms, ml, mr, me;
  logic [23:0] maddr;
  logic [15:0] dq_hist [0:8191];

  always @(posedge sys_clk) begin
    dq_hist[cyc & 8191] = rd_sdram_data;
    if (sys_rst) bv = 0;
    else if ((!bv || cyc > me) && rd_en && init_end) begin
      bv    = 1;
      ms    = cyc;
      maddr = rd_addr;
      ml    = (rd_burst_len == 0) ? 1 : (rd_burst_len > 512) ? 512 : int'(rd_burst_len);
      mr    = ms + 3 + TRCD;
      me    = mr + ml + CL + 1 + TRP;
    end
    cyc = cyc + 1;
  end

  logic [15:0] last_data = 16'd0;
  always @(negedge sys_clk) begin
    logic [3:0]  ec;
    logic [1:0]  eba;
    logic [12:0] ea;
    logic        ewr, ebusy, eend;
    ec = C_NOP; eba = 2'b11; ea = 13'h1fff; ewr = 0; ebusy = 0; eend = 0;
    if (sys_rst) last_data = 16'd0;
    else if (bv) begin
      if (cyc == ms + 2) begin ec = C_ACT; eba = maddr[23:22]; ea = maddr[21:9]; end
      else if (cyc == mr) begin ec = C_RD; eba = maddr[23:22]; ea = {4'b0, maddr[8:0]}; end
      else if (cyc == mr + ml) ec = C_BT;
      else if (cyc == mr + ml + CL + 1) ec = C_PRE;
      ebusy = (cyc >= ms + 1) && (cyc <= me);
      eend  = (cyc == me);
      ewr   = (cyc >= mr + CL + 1) && (cyc <= mr + CL + ml);
      if (ewr) last_data = dq_hist[(cyc - 1) & 8191];
    end
    chk("bus", {13'd0, read_cmd, read_ba, read_addr}, {13'd0, ec, eba, ea});
    chk("fifo", {15'd0, rd_fifo_wr_en, rd_fifo_wr_data}, {15'd0, ewr, last_data});
    chk("status", {30'd0, rd_busy, rd_end}, {30'd0, ebusy, eend});
  end

  // Event recorder for the literal timing pins.
  int          act_c, rd_c, bt_c, pre_c, end_c, first_wr_c, last_wr_c;
  int          end_cnt = 0, wr_total = 0;
  logic [1:0]  act_ba, rd_ba;
  logic [12:0] act_a, rd_a, pre_a;
  logic [15:0] first_wr_d;
  logic        prev_wr = 1'b0;
  always @(negedge sys_clk) begin
    case (read_cmd)
      C_ACT: begin act_c = cyc; act_ba = read_ba; act_a = read_addr; end
      C_RD:  begin rd_c = cyc; rd_ba = read_ba; rd_a = read_addr; end
      C_BT:  bt_c = cyc;
      C_PRE: begin pre_c = cyc; pre_a = read_addr; end
      default: ;
    endcase
    if (rd_fifo_wr_en) begin
      wr_total++;
      last_wr_c = cyc;
      if (!prev_wr) begin first_wr_c = cyc; first_wr_d = rd_fifo_wr_data; end
    end
    prev_wr = rd_fifo_wr_en;
    if (rd_end) begin
      end_c = cyc;
      end_cnt++;
      $display("burst end at cycle %0d, words so far %0d", cyc, wr_total);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start(input logic [23:0] a, input logic [9:0] l, output int c0);
    tick();
    rd_addr = a; rd_burst_len = l; rd_en = 1'b1;
    c0 = cyc;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int budget);
    int n0, k;
    n0 = end_cnt; k = 0;
    while (end_cnt == n0 && k < budget) begin
      @(posedge sys_clk);
      k++;
    end
    chk(nm, 32'(end_cnt != n0), 32'd1);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, w0, end1;
    repeat (3) tick();
    chk("rst_cmd", read_cmd, C_NOP);
    chk("rst_ba", read_ba, 2'b11);
    chk("rst_addr", read_addr, 13'h1fff);
    chk("rst_wr", {rd_fifo_wr_en, rd_fifo_wr_data, rd_end, rd_busy}, 19'd0);
    sys_rst = 1'b0; init_end = 1'b1;
    repeat (2) tick();

    // Nominal len=4 burst.
    w0 = wr_total;
    start(24'h400203, 10'd4, c0);
    wait_end("t1_done", 100);
    chk("t1_act", act_c - c0, 2);
    chk("t1_act_bus", {act_ba, act_a}, {2'b01, 13'h0001});
    chk("t1_rd", rd_c - c0, 5);
    chk("t1_rd_bus", {rd_ba, rd_a}, {2'b01, 13'h0003});
    chk("t1_bterm", bt_c - c0, 9);
    chk("t1_wr_first", first_wr_c - c0, 9);
    chk("t1_wr_last", last_wr_c - c0, 12);
    chk("t1_words", wr_total - w0, 4);
    chk("t1_data0", first_wr_d, 16'hD000 | 16'((c0 + 8) & 'hfff));
    chk("t1_pre", pre_c - c0, 13);
    chk("t1_pre_a", pre_a, 13'h1fff);
    chk("t1_end", end_c - c0, 15);

    // len=1 and len=0 both give one word.
    for (int l = 1; l >= 0; l--) begin
      w0 = wr_total;
      start(24'h000010, 10'(l), c0);
      wait_end("short_done", 100);
      chk("short_bterm", bt_c - rd_c, 1);
      chk("short_words", wr_total - w0, 1);
      chk("short_wr", first_wr_c - c0, 9);
      chk("short_end", end_c - c0, 12);
    end

    // len=600 clamps to one page.
    w0 = wr_total;
    start(24'hC00000, 10'd600, c0);
    wait_end("long_done", 700);
    chk("long_words", wr_total - w0, 512);
    chk("long_bterm", bt_c - rd_c, 512);
    chk("long_end", end_c - c0, 523);

    // init_end low blocks the start; rd_en stays high afterwards.
    tick();
    init_end = 1'b0; rd_en = 1'b1; rd_addr = 24'h123456; rd_burst_len = 10'd2;
    repeat (5) tick();
    chk("noinit_busy", rd_busy, 1'b0);
    chk("noinit_cmd", read_cmd, C_NOP);
    init_end = 1'b1;
    c1 = cyc;
    w0 = wr_total;
    tick();
    rd_en = 1'b0; rd_addr = 24'hFFFFFF; rd_burst_len = 10'd9;
    tick(); rd_en = 1'b1;
    tick(); rd_en = 1'b0;
    tick(); rd_en = 1'b1;
    wait_end("init_done", 100);
    chk("init_act", act_c - c1, 2);
    chk("init_rd_bus", {rd_ba, rd_a}, {2'b00, 13'h0056});
    chk("init_words", wr_total - w0, 2);
    chk("init_end", end_c - c1, 13);
    end1 = end_c;
    wait_end("b2b_done", 100);
    rd_en = 1'b0;
    chk("b2b_act", act_c - end1, 3);

    // Reset in the middle of the data phase.
    start(24'h812345, 10'd20, c0);
    repeat (9) tick();
    chk("mid_wr_before", rd_fifo_wr_en, 1'b1);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_cmd", read_cmd, C_NOP);
    chk("mid_rst_wr", rd_fifo_wr_en, 1'b0);
    chk("mid_rst_busy", rd_busy, 1'b0);
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    w0 = wr_total;
    start(24'h400203, 10'd4, c0);
    wait_end("post_done", 100);
    chk("post_act", act_c - c0, 2);
    chk("post_words", wr_total - w0, 4);
    chk("post_end", end_c - c0, 15);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sdram_read.md
Name: sdram_read

Overview:
- Executes one read burst into the SDRAM.
- Sequence: activate the bank/row, wait tRCD, issue READ, capture rd_burst_len words after CAS latency, burst-stop, precharge all banks, wait tRP, pulse rd_end.
- Sits beside sdram_write under the SDRAM arbiter, which muxes the command/bank/address buses and drives rd_en.
- Captured words are pushed into the read-side FIFO.

Parameters:
- CAS_LATENCY, 3, cycles from the READ command to the first valid dq word (must match the mode register).
- RD_TRCD_CLK, 2, wait cycles after the ACTIVE command.
- RD_TRP_CLK, 2, wait cycles after the PRECHARGE command.

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst  in  1  asynchronous, active-high reset
- init_end  in  1  SDRAM initialisation complete
- rd_en  in  1  read request from the arbiter
- rd_addr  in  24  {bank[23:22], row[21:9], col[8:0]}
- rd_burst_len  in  10  words to read
- rd_sdram_data  in  16  SDRAM dq input
- rd_fifo_wr_en  out  1  read-FIFO write strobe
- rd_fifo_wr_data  out  16  registered dq word
- rd_end  out  1  one-cycle end-of-burst pulse
- rd_busy  out  1  high whenever the state is not RD_IDLE
- read_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
- read_ba  out  2  bank address
- read_addr  out  13  A12..A0

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state RD_IDLE, counter 0.
  - read_cmd NOP, read_ba 2'b11, read_addr 13'h1fff.
  - rd_fifo_wr_en 0, rd_fifo_wr_data 0, rd_end 0.
- Command encodings: NOP 0111, ACTIVE 0011, READ 0101, B_TERM 0110, PRECHARGE 0010.
- Outputs are registered from the current state: a command appears one cycle after its state.
- Start condition: in RD_IDLE with rd_en & init_end high at a clock edge.
  - rd_addr and rd_burst_len are latched at that edge.
  - Length 0 is treated as 1; lengths above 512 are clamped to 512 (one full page).
- rd_en while busy is ignored; rd_addr/rd_burst_len changes after the start edge have no effect.
- States and transitions:
  - RD_IDLE -> RD_ACTIVE on the start condition.
  - RD_ACTIVE -> RD_TRCD.
  - RD_TRCD counts 0..RD_TRCD_CLK-1, then -> RD_READ.
  - RD_READ -> RD_RDATA.
  - RD_RDATA counts 0..len-1, then -> RD_CL.
  - RD_CL counts 0..CAS_LATENCY-1, then -> RD_PRE.
  - RD_PRE -> RD_TRP.
  - RD_TRP counts 0..RD_TRP_CLK-1, then -> RD_END.
  - RD_END -> RD_IDLE.
  - Counter clears on every state change.
- Bus values:
  - ACTIVE: ba = addr[23:22], addr = addr[21:9].
  - READ: ba = addr[23:22], addr = {4'b0, addr[8:0]}; A10 = 0, so no auto-precharge.
  - PRECHARGE: ba 2'b11, addr 13'h1fff (A10 = 1, all banks).
  - B_TERM: ba 2'b11, addr 13'h1fff; issued from RD_RDATA when the count equals len-1.
  - All other cycles: NOP, ba 2'b11, addr 13'h1fff.
- Data timing:
  - Let R be the cycle the READ command is on the bus.
  - Word i is on rd_sdram_data during cycle R+CAS_LATENCY+i.
  - It is registered into rd_fifo_wr_data, with rd_fifo_wr_en high in cycle R+CAS_LATENCY+i+1, for i = 0..len-1.
  - rd_fifo_wr_en is high for exactly len contiguous cycles.
  - rd_fifo_wr_data holds its last value when rd_fifo_wr_en is low.
- Bus ordering: PRECHARGE appears at cycle R+len+CAS_LATENCY+1, after the last dq word.
- Back-to-back: rd_en held high restarts from RD_IDLE one cycle after rd_end, giving a minimum one idle cycle between bursts.
- The SDRAM must be programmed for full-page burst.
- No FIFO backpressure exists; the FIFO must have space for len words before rd_en is asserted.

Test Plan:
- Reset, init_end=1, rd_en pulse at cycle 0, rd_addr=24'h400203, len=4, CL=3 -> expected bus and FIFO activity:
  - ACTIVE at cycle 2 with ba=01, addr=13'h0001.
  - READ at cycle 5 with ba=01, addr=13'h0003.
  - B_TERM at cycle 9.
  - rd_fifo_wr_en high cycles 9..12, carrying the dq values from cycles 8..11 in order.
  - PRECHARGE at cycle 13 with addr=13'h1fff.
  - rd_end high at cycle 15 only.
- len=1 and len=0 -> each gives exactly one wr_en pulse, B_TERM one cycle after READ, otherwise identical timing.
- len=600 -> clamped: exactly 512 wr_en pulses, B_TERM at R+512.
- init_end=0 with rd_en=1 -> stays RD_IDLE, NOP on the bus, rd_busy=0; raising init_end starts the burst on the next edge.
- rd_en toggled and rd_addr changed mid-burst -> no effect on the current burst; held rd_en starts the next burst at the cycle after rd_end.
- sys_rst asserted during RD_RDATA -> immediately read_cmd=NOP, rd_fifo_wr_en=0, rd_busy=0; after release, a new burst runs with the nominal timing.
